// File: rtl/div_pkg.sv
// Shared types and constants for the shift-subtract divider.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    ITER = 2'b01,
    FIN  = 2'b10
  } state_t;

  localparam int DIV_WIDTH_DEFAULT = 8;

  // One extra bit so the counter can represent WIDTH itself.
  function automatic int cnt_width(input int width);
    return $clog2(width) + 1;
  endfunction

  localparam int DIV_CNT_W_DEFAULT = cnt_width(DIV_WIDTH_DEFAULT);

endpackage

// File: rtl/fullAdder.sv
// One-bit full adder cell shared by the arithmetic unit's ripple datapaths.
module fullAdder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/sub_nbit.sv
// N-bit ripple subtractor: diff = a - b computed as a + ~b + 1.
// cout = 1 means no borrow (a >= b).
module sub_nbit #(
  parameter int N = 9
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] diff,
  output logic         cout
);

  logic [N:0] carry;

  assign carry[0] = 1'b1;

  for (genvar i = 0; i < N; i++) begin : g_bit
    fullAdder u_fa (
      .a    (a[i]),
      .b    (~b[i]),
      .cin  (carry[i]),
      .sum  (diff[i]),
      .cout (carry[i+1])
    );
  end

  assign cout = carry[N];

endmodule

// File: rtl/shift_sub_divider.sv
// Sequential restoring unsigned divider, one quotient bit per clock.
// Optional early exit on a zero divisor: define DIV_ZERO_CHECK_EN.
//
// state | meaning
// IDLE  | waiting for START; RQ/RR hold the last result
// ITER  | one shift-subtract step per edge, WIDTH steps total
// FIN   | DONE pulse for one cycle, results valid
module shift_sub_divider
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             START,
  input  logic [WIDTH-1:0] A_in,
  input  logic [WIDTH-1:0] B_in,
  output logic [WIDTH-1:0] RQ,
  output logic [WIDTH-1:0] RR,
  output logic             BUSY,
  output logic             DONE,
  output logic             DZ
);

  localparam int CNT_W = cnt_width(WIDTH);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] divisor;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   diff;
  logic             no_borrow;
  logic             last_iter;
  logic             diff_msb_unused;

  assign shifted   = {RR, RQ[WIDTH-1]};
  assign last_iter = (cnt == CNT_W'(WIDTH - 1));

  sub_nbit #(.N(WIDTH + 1)) u_sub (
    .a    (shifted),
    .b    ({1'b0, divisor}),
    .diff (diff),
    .cout (no_borrow)
  );

  // A restoring step never leaves a remainder wider than the divisor.
  assign diff_msb_unused = diff[WIDTH];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (START) begin
`ifdef DIV_ZERO_CHECK_EN
          if (B_in == '0) state_nxt = FIN;
          else            state_nxt = ITER;
`else
          state_nxt = ITER;
`endif
        end
      end
      ITER:    if (last_iter) state_nxt = FIN;
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign BUSY = (state == ITER);
  assign DONE = (state == FIN);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt     <= '0;
      divisor <= '0;
      RQ      <= '0;
      RR      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (START) begin
            divisor <= B_in;
            cnt     <= '0;
`ifdef DIV_ZERO_CHECK_EN
            if (B_in == '0) begin
              RQ <= '1;
              RR <= A_in;
            end else begin
              RQ <= A_in;
              RR <= '0;
            end
`else
            RQ <= A_in;
            RR <= '0;
`endif
          end
        end
        ITER: begin
          RR  <= no_borrow ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
          RQ  <= {RQ[WIDTH-2:0], no_borrow};
          cnt <= cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef DIV_ZERO_CHECK_EN
  logic dz;

  // Cleared on every accepted START; held until the next one.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                       dz <= 1'b0;
    else if (state == IDLE && START)  dz <= (B_in == '0);
  end

  assign DZ = dz;
`else
  assign DZ = 1'b0;
`endif

endmodule

// File: tb/tb_shift_sub_divider.sv
// Directed bench for shift_sub_divider (WIDTH=8); honours DIV_ZERO_CHECK_EN.
module tb_shift_sub_divider;

  localparam int W = 8;
`ifdef DIV_ZERO_CHECK_EN
  localparam bit ZC = 1'b1;
`else
  localparam bit ZC = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset;
  logic         START;
  logic [W-1:0] A_in, B_in, RQ, RR;
  logic         BUSY, DONE, DZ;

  int n_checks = 0;
  int n_errors = 0;

  shift_sub_divider #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .START (START),
    .A_in  (A_in),
    .B_in  (B_in),
    .RQ    (RQ),
    .RR    (RR),
    .BUSY  (BUSY),
    .DONE  (DONE),
    .DZ    (DZ)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input int a, input int b, input int eq, input int er,
                        input int edz, input int elat);
    int cycles;
    int busy;
    string t;
    t = $sformatf("%0d/%0d", a, b);
    A_in  = W'(a);
    B_in  = W'(b);
    START = 1'b1;
    tick();
    START  = 1'b0;
    cycles = 1;
    busy   = 0;
    while (!DONE && cycles < 40) begin
      if (BUSY) busy++;
      tick();
      cycles++;
    end
    check({t, " latency"}, cycles, elat);
    check({t, " busy_cycles"}, busy, elat - 1);
    check({t, " busy_at_done"}, BUSY, 0);
    check({t, " q"}, RQ, eq);
    check({t, " r"}, RR, er);
    check({t, " dz"}, DZ, edz);
    tick();
    check({t, " done_pulse"}, DONE, 0);
    check({t, " hold_q"}, RQ, eq);
    check({t, " hold_r"}, RR, er);
  endtask

  initial begin
    int ndone;
    int gap;
    logic [W-1:0] cap_q, cap_r;

    reset = 1'b0;
    START = 1'b0;
    A_in  = '0;
    B_in  = '0;
    tick();
    tick();
    check("rst q", RQ, 0);
    check("rst r", RR, 0);
    check("rst busy", BUSY, 0);
    check("rst done", DONE, 0);
    check("rst dz", DZ, 0);
    reset = 1'b1;
    tick();

    run_op(100, 7, 14, 2, 0, 9);
    run_op(255, 1, 255, 0, 0, 9);
    run_op(5, 9, 0, 5, 0, 9);
    run_op(0, 3, 0, 0, 0, 9);
    run_op(200, 200, 1, 0, 0, 9);

    run_op(200, 0, 255, 200, ZC, ZC ? 1 : 9);
    tick();
    check("dz hold", DZ, ZC);
    run_op(9, 2, 4, 1, 0, 9);

    // START pulsed during iteration 4 must be ignored
    A_in = 8'd100; B_in = 8'd7; START = 1'b1;
    tick();
    START = 1'b0;
    repeat (4) tick();
    A_in = 8'd50; B_in = 8'd3; START = 1'b1;
    tick();
    START = 1'b0;
    ndone = 0;
    cap_q = '0;
    cap_r = '0;
    for (int i = 0; i < 25; i++) begin
      if (DONE) begin
        ndone++;
        cap_q = RQ;
        cap_r = RR;
      end
      tick();
    end
    check("busy_rej done_count", ndone, 1);
    check("busy_rej q", cap_q, 14);
    check("busy_rej r", cap_r, 2);

    // asynchronous reset at iteration 5
    A_in = 8'd100; B_in = 8'd7; START = 1'b1;
    tick();
    START = 1'b0;
    repeat (5) tick();
    #2 reset = 1'b0;
    #1;
    check("midrst q", RQ, 0);
    check("midrst r", RR, 0);
    check("midrst busy", BUSY, 0);
    check("midrst done", DONE, 0);
    tick();
    tick();
    reset = 1'b1;
    ndone = 0;
    for (int i = 0; i < 15; i++) begin
      if (DONE) ndone++;
      tick();
    end
    check("midrst no_done", ndone, 0);
    run_op(9, 2, 4, 1, 0, 9);

    // back-to-back with START held high
    A_in = 8'd100; B_in = 8'd7; START = 1'b1;
    tick();
    gap = 1;
    while (!DONE && gap < 40) begin
      tick();
      gap++;
    end
    check("b2b first latency", gap, 9);
    check("b2b first q", RQ, 14);
    check("b2b first r", RR, 2);
    A_in = 8'd63; B_in = 8'd8;
    tick();
    gap = 1;
    while (!DONE && gap < 40) begin
      tick();
      gap++;
    end
    check("b2b gap", gap, 10);
    check("b2b second q", RQ, 7);
    check("b2b second r", RR, 7);
    START = 1'b0;
    tick();
    check("b2b done_pulse", DONE, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/shift_sub_divider.md
Name: shift_sub_divider

Overview:
- Sequential restoring (shift-subtract) unsigned divider; the inverse datapath to the team's shift-add multiplier.
- Computes one quotient bit per clock from a WIDTH-bit dividend and a WIDTH-bit divisor.
- Returns the quotient and remainder with a START/BUSY/DONE handshake.
- Sits beside shift_add in the arithmetic unit and reuses the ripple fullAdder cells for its subtractor.

Parameters:
- WIDTH, 8: operand, quotient and remainder width in bits (legal values 2 to 32).

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low; clears all state.
- START  input  1  request; sampled only in IDLE.
- A_in  input  WIDTH  dividend; captured when START is accepted.
- B_in  input  WIDTH  divisor; captured when START is accepted.
- RQ  output  WIDTH  quotient register.
- RR  output  WIDTH  remainder register.
- BUSY  output  1  high from acceptance through the final iteration.
- DONE  output  1  single-cycle pulse; RQ/RR valid.
- DZ  output  1  divide-by-zero flag; valid with DONE.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low. Port names are clk and reset.
- Reset (asserted at any time, including mid-operation): state goes to IDLE; the iteration counter, RQ, RR, divisor register, BUSY, DONE and DZ all go to 0. The operation in flight is discarded with no DONE pulse.
- States: IDLE, ITER, FIN.
- IDLE:
  - BUSY=0.
  - When START=1 at an edge: divisor register <= B_in, RQ <= A_in, RR <= 0, count <= 0, DZ <= 0, go to ITER.
  - RQ and RR hold their previous results until that accepting edge.
- ITER (BUSY=1), each edge:
  - shifted = {RR, RQ[WIDTH-1]} (WIDTH+1 bits).
  - diff = shifted - {0, divisor}, formed with a ripple subtractor: shifted + ~divisor + 1; carry-out 1 means non-negative.
  - If non-negative: RR <= diff[WIDTH-1:0], RQ <= {RQ[WIDTH-2:0], 1}.
  - Otherwise: RR <= shifted[WIDTH-1:0], RQ <= {RQ[WIDTH-2:0], 0}.
  - count <= count+1. After the WIDTH-th iteration (count == WIDTH-1 at the edge), go to FIN.
- FIN: DONE=1 and BUSY=0 for exactly one cycle, then go to IDLE.
- Latency: the accepting edge is edge 0. DONE is high in the cycle following edge WIDTH, so 9 cycles for WIDTH=8.
- START while BUSY or in FIN: ignored, with no effect on the operation.
- START held high: a new operation is accepted on the first IDLE edge after FIN.
- Divisor = 0 without the optional feature: the iteration runs normally and yields RQ = all ones, RR = dividend, DZ=0.
- Width rules:
  - Counter width = clog2(WIDTH)+1.
  - The counter never wraps in normal use.
  - No overflow is possible for unsigned division.

Optional Feature:
- Macro: DIV_ZERO_CHECK_EN.
- When defined:
  - If B_in == 0 at the accepting edge, the block skips ITER: RQ <= all ones, RR <= A_in, DZ <= 1, go straight to FIN.
  - DONE is high in the cycle after edge 0 (latency 1).
  - DZ holds until the next accepted START or reset.
- When undefined: DZ is tied 0 and divide-by-zero takes the full WIDTH-cycle path with the results stated above.

Decomposition:
- Package div_pkg holds:
  - the state encoding constants IDLE=2'b00, ITER=2'b01, FIN=2'b10;
  - DIV_WIDTH_DEFAULT = 8;
  - the counter-width constant derived from WIDTH.
- One sub-module, sub_nbit (WIDTH+1 bits): ripple subtractor built from fullAdder cells. Outputs the difference and carry-out; carry-out 1 means no borrow.
- The control FSM and datapath registers stay in shift_sub_divider.

Test Plan:
- Basic division: reset low for 2 cycles, release; START with A_in=100, B_in=7 -> BUSY for 8 cycles; DONE in cycle 9; RQ=14, RR=2, DZ=0.
- Boundary operands: A_in=255, B_in=1 -> RQ=255, RR=0. A_in=5, B_in=9 -> RQ=0, RR=5. A_in=0, B_in=3 -> RQ=0, RR=0. A_in=B_in=200 -> RQ=1, RR=0.
- Divide by zero: A_in=200, B_in=0 -> RQ=255, RR=200.
  - With DIV_ZERO_CHECK_EN: DONE one cycle after acceptance, DZ=1.
  - Without it: DONE after 9 cycles, DZ=0.
- Busy rejection: pulse START with A_in=50, B_in=3 at iteration 4 of an active 100/7 operation -> the result is still 14 r 2; only one DONE pulse.
- Reset mid-operation: assert reset at iteration 5 -> RQ, RR, BUSY and DONE go to 0 immediately (asynchronously); no DONE pulse. After release, 9/2 -> RQ=4, RR=1.
- Back-to-back: hold START=1 across operations 100/7 then 63/8 -> the second operation is accepted the cycle after FIN; results 14 r 2 then 7 r 7.
